fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-pipeline types and constants: FSM state encoding, widths, reset PC.
package fetch_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO between instruction memory and IF_ID.
module fetch_queue
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    output logic [ADDR_W-1:0]  o_head_pc,
    output logic [INSTR_W-1:0] o_head_instr,
    output logic [1:0]         o_count,
    output logic               o_full,
    output logic               o_empty
);

    fq_entry_t  r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= '{pc: i_pc, instr: i_instr};
        end
    end

    assign o_head_pc    = o_empty ? '0 : r_mem[r_rd_ptr].pc;
    assign o_head_instr = o_empty ? '0 : r_mem[r_rd_ptr].instr;
    assign o_count      = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding memory requests feeding a 2-entry queue
// whose head drives IF_ID; redirects flush the queue and drop in-flight responses.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned       FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               Stall,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  Redirect_TA,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] Instr_OUT,
    output logic [ADDR_W-1:0]  PCOG,
    output logic [ADDR_W-1:0]  PC4,
    output logic               LE,
    output logic               resetIF
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_req_addr;
    logic               w_issue;
    logic               w_push;
    logic               w_room;
    logic [1:0]         w_count;
    logic               w_full;
    logic               w_empty;
    logic [ADDR_W-1:0]  w_head_pc;
    logic [INSTR_W-1:0] w_head_instr;

    assign w_room = !w_full && (32'(w_count) < FQ_DEPTH);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_issue) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (Redirect)         w_state_nxt = imem_rvalid ? ST_IDLE : ST_DRAIN;
                else if (imem_rvalid) w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: if (imem_rvalid) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A response pushes only in WAIT without a concurrent redirect.
    always_comb begin
        w_issue = 1'b0;
        w_push  = 1'b0;
        case (r_state)
            ST_IDLE: w_issue = w_room && !Redirect;
            ST_WAIT: w_push  = imem_rvalid && !Redirect;
            default: begin
                w_issue = 1'b0;
                w_push  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            if (Redirect)    r_pc <= align_word(Redirect_TA);
            else if (w_push) r_pc <= r_pc + 32'd4;
            if (w_issue) r_req_addr <= r_pc;
        end
    end

    fetch_queue u_queue (
        .clk          (clk),
        .i_rst_n      (Reset),
        .i_push       (w_push),
        .i_pop        (LE),
        .i_flush      (Redirect),
        .i_pc         (r_req_addr),
        .i_instr      (imem_rdata),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Request is masked while reset is held so the interface is quiet immediately.
    assign imem_req  = w_issue && Reset;
    assign imem_addr = r_pc;
    assign LE        = !w_empty && !Stall && !Redirect;
    assign resetIF   = Redirect;
    assign Instr_OUT = w_head_instr;
    assign PCOG      = w_head_pc;
    assign PC4       = w_empty ? '0 : w_head_pc + 32'd4;

endmodule
